// File: rtl/kbd_event_sequencer_pkg.sv
// Shared types for the PET keyboard event sequencer.
// KBD_SEQ_RELEASE_ALL_EN adds the release-all (CLR) state.
package kbd_event_sequencer_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int WB_ADDR_WIDTH = 8;
    localparam int KBD_COL_COUNT = 10;
    localparam int KBD_ROW_WIDTH = 3;

    localparam logic [3:0] KBD_EVT_COL_ALL = 4'hF;

    typedef struct packed {
        logic                     is_release;
        logic [KBD_ROW_WIDTH-1:0] row;
        logic [3:0]               col;
    } kbd_evt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_ACK,
        S_WR_REQ,
        S_WR_ACK,
`ifdef KBD_SEQ_RELEASE_ALL_EN
        S_GAP,
        S_CLR
`else
        S_GAP
`endif
    } kbd_seq_state_t;

    // Matrix is active-low: a pressed key reads as 0.
    function automatic logic [DATA_WIDTH-1:0] apply_evt(
        input logic [DATA_WIDTH-1:0] d,
        input kbd_evt_t              e
    );
        logic [DATA_WIDTH-1:0] mask;
        mask = DATA_WIDTH'(1) << e.row;
        return e.is_release ? (d | mask) : (d & ~mask);
    endfunction

endpackage

// File: rtl/kbd_event_sequencer_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty derive from the count.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kbd_event_sequencer.sv
// Wishbone master applying key events to the PET matrix by column RMW.
// KBD_SEQ_RELEASE_ALL_EN: column 4'hF writes 8'hFF to every column.
module kbd_event_sequencer
    import kbd_event_sequencer_pkg::*;
#(
    parameter int                       FIFO_DEPTH     = 8,
    parameter int                       MIN_GAP_CYCLES = 1_000_000,
    parameter logic [WB_ADDR_WIDTH-1:0] KBD_BASE_ADDR  = '0
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_n_i,
    input  logic                     evt_valid_i,
    output logic                     evt_ready_o,
    input  logic [7:0]               evt_data_i,
    output logic [WB_ADDR_WIDTH-1:0] wbm_addr_o,
    output logic [DATA_WIDTH-1:0]    wbm_data_o,
    input  logic [DATA_WIDTH-1:0]    wbm_data_i,
    output logic                     wbm_we_o,
    output logic                     wbm_cycle_o,
    output logic                     wbm_strobe_o,
    input  logic                     wbm_stall_i,
    input  logic                     wbm_ack_i,
    output logic                     busy_o,
    output logic                     err_o,
    input  logic                     err_clr_i
);

    localparam int GAP_W = (MIN_GAP_CYCLES > 0) ? $clog2(MIN_GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((MIN_GAP_CYCLES > 0) ? MIN_GAP_CYCLES - 1 : 0);

    kbd_seq_state_t        state, state_n;
    kbd_evt_t              evt_q, evt_n, fifo_evt;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [GAP_W-1:0]      gap_q, gap_n;
    logic [7:0]            fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic                  run_q, pop, bad_col, overflow;
`ifdef KBD_SEQ_RELEASE_ALL_EN
    logic [3:0]            clr_q, clr_n;
    logic                  clr_wait_q, clr_wait_n;
`endif

    assign fifo_evt    = kbd_evt_t'(fifo_dout);
    assign evt_ready_o = run_q && !fifo_full;
    assign overflow    = evt_valid_i && fifo_full;
    assign busy_o      = (state != S_IDLE) || !fifo_empty;

    sync_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clock_i),
        .rst_n (wb_reset_n_i),
        .push  (evt_valid_i && evt_ready_o),
        .pop   (pop),
        .din   (evt_data_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state      <= S_IDLE;
            evt_q      <= '0;
            wdata_q    <= '0;
            gap_q      <= '0;
            run_q      <= 1'b0;
            err_o      <= 1'b0;
`ifdef KBD_SEQ_RELEASE_ALL_EN
            clr_q      <= '0;
            clr_wait_q <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            evt_q      <= evt_n;
            wdata_q    <= wdata_n;
            gap_q      <= gap_n;
            run_q      <= 1'b1;
            // A new error outranks a simultaneous clear.
            if (overflow || bad_col) err_o <= 1'b1;
            else if (err_clr_i)      err_o <= 1'b0;
`ifdef KBD_SEQ_RELEASE_ALL_EN
            clr_q      <= clr_n;
            clr_wait_q <= clr_wait_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        evt_n        = evt_q;
        wdata_n      = wdata_q;
        gap_n        = gap_q;
        pop          = 1'b0;
        bad_col      = 1'b0;
        wbm_cycle_o  = 1'b0;
        wbm_strobe_o = 1'b0;
        wbm_we_o     = 1'b0;
        wbm_addr_o   = '0;
        wbm_data_o   = '0;
`ifdef KBD_SEQ_RELEASE_ALL_EN
        clr_n        = clr_q;
        clr_wait_n   = clr_wait_q;
`endif
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    evt_n = fifo_evt;
                    if (fifo_evt.col < 4'(KBD_COL_COUNT)) begin
                        state_n = S_RD_REQ;
`ifdef KBD_SEQ_RELEASE_ALL_EN
                    end else if (fifo_evt.col == KBD_EVT_COL_ALL) begin
                        state_n    = S_CLR;
                        clr_n      = '0;
                        clr_wait_n = 1'b0;
`endif
                    end else begin
                        bad_col = 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                wbm_cycle_o  = 1'b1;
                wbm_strobe_o = 1'b1;
                wbm_addr_o   = KBD_BASE_ADDR + WB_ADDR_WIDTH'(evt_q.col);
                if (!wbm_stall_i) state_n = S_RD_ACK;
            end
            S_RD_ACK: begin
                wbm_cycle_o = 1'b1;
                if (wbm_ack_i) begin
                    wdata_n = apply_evt(wbm_data_i, evt_q);
                    state_n = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                wbm_cycle_o  = 1'b1;
                wbm_strobe_o = 1'b1;
                wbm_we_o     = 1'b1;
                wbm_addr_o   = KBD_BASE_ADDR + WB_ADDR_WIDTH'(evt_q.col);
                wbm_data_o   = wdata_q;
                if (!wbm_stall_i) state_n = S_WR_ACK;
            end
            S_WR_ACK: begin
                wbm_cycle_o = 1'b1;
                if (wbm_ack_i) begin
                    gap_n   = GAP_LOAD;
                    state_n = (MIN_GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_n = S_IDLE;
                else             gap_n   = gap_q - 1'b1;
            end
`ifdef KBD_SEQ_RELEASE_ALL_EN
            S_CLR: begin
                // One write per column; strobe rests while awaiting each ack.
                wbm_cycle_o  = 1'b1;
                wbm_strobe_o = !clr_wait_q;
                wbm_we_o     = 1'b1;
                wbm_addr_o   = KBD_BASE_ADDR + WB_ADDR_WIDTH'(clr_q);
                wbm_data_o   = '1;
                if (!clr_wait_q && !wbm_stall_i) clr_wait_n = 1'b1;
                if (clr_wait_q && wbm_ack_i) begin
                    clr_wait_n = 1'b0;
                    if (clr_q == 4'(KBD_COL_COUNT - 1)) begin
                        gap_n   = GAP_LOAD;
                        state_n = (MIN_GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        clr_n = clr_q + 1'b1;
                    end
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

endmodule
